// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
//   Owns the PC, issues the instruction SRAM request, and hands {ce, pc} to
//   decode. A branch resolved while IF is stalled is parked in a pending
//   register and applied on the first unstalled edge. A flush (exception or
//   eret) overrides everything, including the stall.
// Ports:
//   clk, rst          clock, async active-high reset
//   stall             stall vector, bit 0 freezes IF
//   flush, flush_pc   redirect strobe and target
//   br_bus            {br_e, br_addr} from decode (same cycle)
//   if_to_id_bus      {ce, pc} of the current fetch
//   inst_sram_*       fetch request (read-only: wen/wdata tied off)
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          IF_TO_ID_WD = 33,
  parameter int          BR_WD       = 33,
  parameter int          STALL_WD    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  logic [31:0] r_pc;
  logic        r_ce;
  logic        r_pend;
  logic [31:0] r_pend_addr;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_unused_stall;

  assign w_br_e         = br_bus[32];
  assign w_br_addr      = br_bus[31:0];
  // Upper stall bits belong to later stages.
  assign w_unused_stall = |stall[STALL_WD-1:1];

  // Redirect priority: flush > live branch > parked branch > sequential.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (flush)       w_next_pc = flush_pc;
    else if (w_br_e) w_next_pc = w_br_addr;
    else if (r_pend) w_next_pc = r_pend_addr;
  end

  // Reset PC sits one word below RESET_PC so the first +4 lands on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC - 32'd4;
      r_ce        <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= 32'd0;
    end else if (flush || !stall[0]) begin
      r_pc   <= w_next_pc;
      r_ce   <= 1'b1;
      r_pend <= 1'b0;
    end else if (w_br_e) begin
      // Stalled: keep the PC, remember the newest branch target.
      r_pend      <= 1'b1;
      r_pend_addr <= w_br_addr;
    end
  end

  assign if_to_id_bus    = {r_ce, r_pc};
  assign inst_sram_en    = r_ce;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0; br_bus = '0;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFBF_FFFC) begin errors++; $display("FAIL rst_addr got %h exp %h", inst_sram_addr, 32'hBFBF_FFFC); end
    checks++;
    if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", inst_sram_en); end
    checks++;
    if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin errors++; $display("FAIL rst_bus got %h exp %h", if_to_id_bus, {1'b0, 32'hBFBF_FFFC}); end
    checks++;
    if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin errors++; $display("FAIL rst_wen got %h/%h exp 0/0", inst_sram_wen, inst_sram_wdata); end
    rst = 1'b0;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL first_fetch got %h en %b exp bfc00000 en 1", inst_sram_addr, inst_sram_en); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL seq1 got %h exp bfc00004", inst_sram_addr); end
    step();
    checks++;
    if (if_to_id_bus !== {1'b1, 32'hBFC0_0008} || inst_sram_wen !== 4'b0000) begin errors++; $display("FAIL seq2 got %h wen %h exp 1bfc00008 wen 0", if_to_id_bus, inst_sram_wen); end
  endtask

  task automatic test_branch();
    // Only stall[0] freezes IF; the upper bits must not.
    stall = 6'b111110;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_000C) begin errors++; $display("FAIL upper_stall got %h exp bfc0000c", inst_sram_addr); end
    stall = '0;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL pre_br got %h exp bfc00010", inst_sram_addr); end
    br_bus = {1'b1, 32'hBFC0_0100};
    step();
    br_bus = '0;
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL br_target got %h exp bfc00100", inst_sram_addr); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0104) begin errors++; $display("FAIL br_next got %h exp bfc00104", inst_sram_addr); end
  endtask

  task automatic test_stall_pending();
    br_bus = {1'b1, 32'hBFC0_0020};
    step();
    br_bus = {1'b1, 32'hBFC0_0200};
    stall  = 6'b000001;
    step();
    br_bus = '0;
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0020 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL stall1 got %h en %b exp bfc00020 en 1", inst_sram_addr, inst_sram_en); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0020) begin errors++; $display("FAIL stall2 got %h exp bfc00020", inst_sram_addr); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0020) begin errors++; $display("FAIL stall3 got %h exp bfc00020", inst_sram_addr); end
    stall = '0;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0200) begin errors++; $display("FAIL pend_apply got %h exp bfc00200", inst_sram_addr); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0204) begin errors++; $display("FAIL pend_clear got %h exp bfc00204", inst_sram_addr); end
  endtask

  task automatic test_flush();
    stall = 6'b000001; flush = 1'b1; flush_pc = 32'hBFC0_0380;
    br_bus = {1'b1, 32'hBFC0_0500};
    step();
    stall = '0; flush = 1'b0; br_bus = '0;
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0380 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL flush got %h en %b exp bfc00380 en 1", inst_sram_addr, inst_sram_en); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0384) begin errors++; $display("FAIL flush_next got %h exp bfc00384", inst_sram_addr); end
  endtask

  task automatic test_wrap();
    br_bus = {1'b1, 32'hFFFF_FFFC};
    step();
    br_bus = '0;
    checks++;
    if (inst_sram_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", inst_sram_addr); end
    step();
    checks++;
    if (if_to_id_bus !== {1'b1, 32'h0000_0000}) begin errors++; $display("FAIL wrap got %h exp 100000000", if_to_id_bus); end
  endtask

  task automatic test_async_reset();
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0700};
    step();
    br_bus = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (inst_sram_addr !== 32'hBFBF_FFFC || inst_sram_en !== 1'b0) begin errors++; $display("FAIL async_rst got %h en %b exp bfbffffc en 0", inst_sram_addr, inst_sram_en); end
    step();
    rst = 1'b0; stall = '0;
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL post_rst got %h en %b exp bfc00000 en 1", inst_sram_addr, inst_sram_en); end
    step();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL post_rst_seq got %h exp bfc00004", inst_sram_addr); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall_pending();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
